// File: rtl/instruction_sequencer.sv
// Fetch/execute controller: fetches 16-bit instructions, feeds the ALU from IR and a
// four-entry register file, writes results back and executes jump/branch/halt itself.
module instruction_sequencer #(
    parameter int unsigned OPCODE_WIDTH      = 4,
    parameter int unsigned REGISTER_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH     = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         resetN,
    output logic [ADDRESS_WIDTH-1:0]     instrAddress,
    output logic                         instrRequest,
    input  logic                         instrValid,
    input  logic [INSTRUCTION_WIDTH-1:0] instrData,
    output logic [OPCODE_WIDTH-1:0]      opCode,
    output logic [REGISTER_WIDTH-1:0]    register1Value,
    output logic [REGISTER_WIDTH-1:0]    register2Value,
    output logic [REGISTER_WIDTH-1:0]    instructionValue,
    input  logic [REGISTER_WIDTH-1:0]    aluResult,
    output logic [REGISTER_WIDTH-1:0]    register0Value,
    output logic                         halted
);

    localparam logic [OPCODE_WIDTH-1:0] OpJump     = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OpJumpZero = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OpHalt     = OPCODE_WIDTH'(12);

    typedef enum logic [1:0] {StIdle, StFetch, StExecute, StHalt} state_e;

    state_e                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]   ir_q, ir_d;
    logic [REGISTER_WIDTH-1:0]      reg_file_q [4];
    logic                           wr_en;
    logic [1:0]                     dest, src;
    logic [ADDRESS_WIDTH-1:0]       target;

    assign opCode           = ir_q[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign dest             = ir_q[11:10];
    assign src              = ir_q[9:8];
    assign instructionValue = ir_q[REGISTER_WIDTH-1:0];
    assign target           = ir_q[ADDRESS_WIDTH-1:0];

    assign register1Value = reg_file_q[dest];
    assign register2Value = reg_file_q[src];
    assign register0Value = reg_file_q[0];

    assign instrAddress = pc_q;
    assign instrRequest = (state_q == StFetch);
    assign halted       = (state_q == StHalt);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (instrValid) begin
                    ir_d    = instrData;
                    state_d = StExecute;
                end
            end
            StExecute: begin
                state_d = StFetch;
                case (opCode)
                    OpJump:     pc_d = target;
                    OpJumpZero: pc_d = (register1Value == '0) ? target
                                                              : pc_q + ADDRESS_WIDTH'(1);
                    OpHalt:     state_d = StHalt;
                    default: begin
                        // Opcodes the ALU does not implement still write its zero result.
                        wr_en = 1'b1;
                        pc_d  = pc_q + ADDRESS_WIDTH'(1);
                    end
                endcase
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                reg_file_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (wr_en) begin
                reg_file_q[dest] <= aluResult;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: instruction-level reference model, directed scenarios and a
// randomized program run with random memory wait states.
module tb_instruction_sequencer;

    logic        clock;
    logic        resetN;
    logic [7:0]  instrAddress;
    logic        instrRequest;
    logic        instrValid;
    logic [15:0] instrData;
    logic [3:0]  opCode;
    logic [7:0]  register1Value;
    logic [7:0]  register2Value;
    logic [7:0]  instructionValue;
    logic [7:0]  aluResult;
    logic [7:0]  register0Value;
    logic        halted;

    instruction_sequencer #(
        .OPCODE_WIDTH      (4),
        .REGISTER_WIDTH    (8),
        .ADDRESS_WIDTH     (8),
        .INSTRUCTION_WIDTH (16)
    ) dut (
        .clock            (clock),
        .resetN           (resetN),
        .instrAddress     (instrAddress),
        .instrRequest     (instrRequest),
        .instrValid       (instrValid),
        .instrData        (instrData),
        .opCode           (opCode),
        .register1Value   (register1Value),
        .register2Value   (register2Value),
        .instructionValue (instructionValue),
        .aluResult        (aluResult),
        .register0Value   (register0Value),
        .halted           (halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [256];
    int          fixed_wait = 0;
    int          cur_wait   = 0;
    int          req_cnt    = 0;

    // Reference model state.
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_regs [4];
    logic        m_halted, m_started, m_exec;
    logic [7:0]  fetch_log [$];

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] imm);
        case (op)
            4'd0:  return imm;
            4'd1:  return b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return ~a;
            4'd8:  return a << 1;
            4'd11: return a + 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    always_comb aluResult = alu_f(opCode, register1Value, register2Value, instructionValue);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: answers after cur_wait wait cycles; junk on the bus whenever not requested.
    always @(negedge clock) begin
        if (instrRequest) begin
            if (req_cnt >= cur_wait) begin
                instrValid = 1'b1;
                instrData  = mem[instrAddress];
                req_cnt    = 0;
                cur_wait   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end else begin
                instrValid = 1'b0;
                instrData  = 16'($urandom);
                req_cnt++;
            end
        end else begin
            instrValid = 1'($urandom_range(0, 1));
            instrData  = 16'($urandom);
            req_cnt    = 0;
        end
    end

    // Instruction-level model: one idle cycle after reset, then fetch / execute pairs.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_pc      <= 8'd0;
            m_ir      <= 16'd0;
            m_halted  <= 1'b0;
            m_started <= 1'b0;
            m_exec    <= 1'b0;
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'd0;
        end else if (m_halted) begin
            m_halted <= 1'b1;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (m_exec) begin
            m_exec <= 1'b0;
            case (m_ir[15:12])
                4'd9:  m_pc <= m_ir[7:0];
                4'd10: m_pc <= (m_regs[m_ir[11:10]] == 8'd0) ? m_ir[7:0] : m_pc + 8'd1;
                4'd12: m_halted <= 1'b1;
                default: begin
                    m_regs[m_ir[11:10]] <= alu_f(m_ir[15:12], m_regs[m_ir[11:10]],
                                                 m_regs[m_ir[9:8]], m_ir[7:0]);
                    m_pc <= m_pc + 8'd1;
                end
            endcase
        end else if (instrValid) begin
            m_ir   <= instrData;
            m_exec <= 1'b1;
            fetch_log.push_back(m_pc);
        end
    end

    always begin
        @(posedge clock);
        #2;
        check("instrRequest", 32'(instrRequest), 32'(m_started && !m_exec && !m_halted));
        check("halted", 32'(halted), 32'(m_halted));
        check("instrAddress", 32'(instrAddress), 32'(m_pc));
        check("opCode", 32'(opCode), 32'(m_ir[15:12]));
        check("register1Value", 32'(register1Value), 32'(m_regs[m_ir[11:10]]));
        check("register2Value", 32'(register2Value), 32'(m_regs[m_ir[9:8]]));
        check("instructionValue", 32'(instructionValue), 32'(m_ir[7:0]));
        check("register0Value", 32'(register0Value), 32'(m_regs[0]));
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        resetN = 1'b0;
        repeat (cycles) @(negedge clock);
        fetch_log.delete();
        cur_wait = (fixed_wait >= 0) ? fixed_wait : 0;
        resetN = 1'b1;
    endtask

    task automatic wait_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clock);
            #3;
            cyc++;
        end
        if (!halted) check("halt_timeout", 32'(halted), 32'd1);
    endtask

    initial begin
        int cyc;
        resetN     = 1'b0;
        instrValid = 1'b0;
        instrData  = 16'd0;
        clear_mem();

        // Reset: all outputs zero, one idle cycle, then fetch from 0.
        repeat (3) @(posedge clock);
        #3;
        check("rst_instrRequest", 32'(instrRequest), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instrAddress", 32'(instrAddress), 32'd0);
        check("rst_opCode", 32'(opCode), 32'd0);
        check("rst_register1Value", 32'(register1Value), 32'd0);
        check("rst_register2Value", 32'(register2Value), 32'd0);
        check("rst_instructionValue", 32'(instructionValue), 32'd0);
        check("rst_register0Value", 32'(register0Value), 32'd0);
        mem[0] = 16'h0405;  // LOAD0 r1,#5
        mem[1] = 16'hB400;  // INCREMENT11 r1
        mem[2] = 16'h2500;  // ADD2 r1,r1
        mem[3] = 16'hC400;  // HALT12, dest r1 so register1Value shows r1
        fixed_wait = 0;
        cur_wait   = 0;
        @(negedge clock);
        fetch_log.delete();
        resetN = 1'b1;
        #1;
        check("idle_instrRequest", 32'(instrRequest), 32'd0);
        @(posedge clock);
        #3;
        check("first_instrRequest", 32'(instrRequest), 32'd1);
        check("first_instrAddress", 32'(instrAddress), 32'd0);
        wait_halt(40, cyc);
        check("arith_cycles", 32'(cyc), 32'd8);
        check("arith_r1", 32'(register1Value), 32'h0C);
        check("arith_model_r1", 32'(m_regs[1]), 32'h0C);
        check("arith_fetch_count", 32'(fetch_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < fetch_log.size(); i++)
            check("arith_fetch_addr", 32'(fetch_log[i]), 32'(i));

        // Wait states: three wait cycles make each instruction five cycles.
        clear_mem();
        mem[0] = 16'h0033;
        fixed_wait = 3;
        do_reset(2);
        wait_halt(60, cyc);
        check("wait_cycles", 32'(cyc), 32'd11);
        check("wait_r0", 32'(register0Value), 32'h33);

        // Conditional branch taken, then not taken.
        clear_mem();
        mem[8'h00] = 16'h0800;
        mem[8'h01] = 16'hA840;
        mem[8'h40] = 16'h0801;
        mem[8'h41] = 16'hA840;
        fixed_wait = 0;
        do_reset(2);
        wait_halt(60, cyc);
        check("jz_fetch_count", 32'(fetch_log.size()), 32'd5);
        if (fetch_log.size() >= 5) begin
            check("jz_taken_addr", 32'(fetch_log[2]), 32'h40);
            check("jz_not_taken_addr", 32'(fetch_log[4]), 32'h42);
        end

        // PC wrap-around from 0xFF.
        clear_mem();
        mem[8'h00] = 16'h90FF;
        mem[8'hFF] = 16'h0C77;
        fixed_wait = 1;
        do_reset(2);
        repeat (14) @(posedge clock);
        #3;
        check("wrap_fetch_count_ge3", 32'(fetch_log.size() >= 3), 32'd1);
        if (fetch_log.size() >= 3) begin
            check("wrap_to_ff", 32'(fetch_log[1]), 32'hFF);
            check("wrap_to_00", 32'(fetch_log[2]), 32'h00);
        end

        // Halt is sticky.
        clear_mem();
        fixed_wait = 0;
        do_reset(2);
        wait_halt(20, cyc);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #3;
            check("halt_sticky", 32'({halted, instrRequest}), 32'b10);
        end

        // Reset during EXECUTE of LOAD0 r0,#0xAA leaves nothing behind.
        clear_mem();
        mem[0] = 16'h00AA;
        do_reset(2);
        @(posedge clock);
        @(posedge clock);
        #3;
        check("midrst_exec_imm", 32'(instructionValue), 32'hAA);
        @(negedge clock);
        resetN = 1'b0;
        #1;
        check("midrst_r0", 32'(register0Value), 32'h00);
        check("midrst_pc", 32'(instrAddress), 32'h00);
        check("midrst_instrRequest", 32'(instrRequest), 32'd0);
        @(posedge clock);
        #3;
        check("midrst_r0_after_edge", 32'(register0Value), 32'h00);
        check("midrst_pc_after_edge", 32'(instrAddress), 32'h00);

        // Random programs with random wait states and occasional resets.
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'd12 && $urandom_range(0, 7) != 0) w[15:12] = 4'd0;
            mem[i] = w;
        end
        fixed_wait = -1;
        do_reset(2);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clock);
            if (halted || $urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode/writeback controller that drives the ALU from the instruction side. It fetches 16-bit instructions from program memory over a request/valid handshake and decodes them into opCode, operand values and immediate for the ALU. It writes aluResult back into a four-entry register file, and it executes the control opcodes (jump, conditional jump, halt) itself. It sits between program ROM and the ALU and together with them forms the CPU core.

## Interface
Parameters:
- OPCODE_WIDTH, 4, opcode field width
- REGISTER_WIDTH, 8, data/register width
- ADDRESS_WIDTH, 8, program counter width
- INSTRUCTION_WIDTH, 16, instruction word width: opcode [15:12], dest [11:10], src [9:8], immediate [7:0]

Ports:
- clock  input  1  single clock, rising edge
- resetN  input  1  asynchronous, active-low reset
- instrAddress  output  ADDRESS_WIDTH  program counter presented to program memory
- instrRequest  output  1  fetch request
- instrValid  input  1  instrData valid; sampled only while instrRequest=1
- instrData  input  INSTRUCTION_WIDTH  fetched instruction
- opCode  output  OPCODE_WIDTH  to ALU, IR[15:12]
- register1Value  output  REGISTER_WIDTH  to ALU, regFile[dest]
- register2Value  output  REGISTER_WIDTH  to ALU, regFile[src]
- instructionValue  output  REGISTER_WIDTH  to ALU, IR[7:0]
- aluResult  input  REGISTER_WIDTH  combinational result from ALU
- register0Value  output  REGISTER_WIDTH  regFile[0], for LEDs/debug
- halted  output  1  high once HALT12 has executed

## Operation
- State machine states: IDLE, FETCH, EXECUTE, HALT.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next edge.
- FETCH:
  - instrRequest=1 and instrAddress=PC, both held stable until instrValid=1 is sampled.
  - On that edge, IR <= instrData and the state moves to EXECUTE.
- EXECUTE: lasts exactly one cycle, with instrRequest=0. The ALU inputs are driven combinationally from IR and the register file. At the edge:
  - JUMP9: PC <= IR[7:0]. No register write.
  - JUMPZERO10: PC <= IR[7:0] if register1Value==0, else PC+1. No register write.
  - HALT12: state moves to HALT. PC unchanged. No register write.
  - All other opcodes: regFile[dest] <= aluResult and PC <= PC+1. This includes opcodes the ALU maps to 0, which write 0.
  - Next state is FETCH, except after HALT12.
- HALT: halted=1 and instrRequest=0. The block stays here until reset.
- PC arithmetic is modulo 2^ADDRESS_WIDTH: 0xFF+1 wraps to 0x00. A jump target wider than the PC is not possible, because immediate width equals ADDRESS_WIDTH.
- dest==src is legal; both ALU operands then read the same register.
- instrValid outside FETCH is ignored, and so is instrData.
- Between instructions (IDLE, FETCH, HALT) the ALU outputs reflect the last IR. Nothing is written in those states.

## Timing
- Reset values, asserted immediately when resetN goes low and independent of clock:
  - state=IDLE, PC=0, IR=0, all registers 0.
  - instrRequest=0, halted=0, instrAddress=0.
  - opCode=0, register1Value=0, register2Value=0, instructionValue=0, register0Value=0.
- After resetN deasserts: first edge IDLE→FETCH, so instrRequest=1 in the following cycle.
- Zero-wait memory: instrValid=1 in the first FETCH cycle gives 2 cycles per instruction. Each wait cycle adds one.
- Register writeback and the PC update occur on the same edge that leaves EXECUTE. The next fetch sees the new PC and the new register values.
- Reset mid-EXECUTE aborts the instruction: no write and no PC update survive.
- Reset mid-FETCH drops the request immediately.

## Test plan
- Reset: hold resetN=0 for 3 cycles. All outputs must be 0. After release, IDLE for 1 cycle, then instrRequest=1 with instrAddress=0x00.
- Arithmetic: fetch LOAD0 r1,#0x05, then INCREMENT11 r1, then ADD2 r1,r1, using a behavioural ALU model. Required: r1=0x05, then 0x06, then 0x0C; instrAddress steps 0,1,2.
- Wait states: delay instrValid by 3 cycles. instrAddress and instrRequest must stay stable, there must be no register writes, and instructions take 5 cycles.
- Conditional branch:
  - JUMPZERO10 r2,#0x40 with r2=0: next instrAddress=0x40.
  - The same instruction with r2=1: next instrAddress=PC+1.
- Wrap-around: JUMP9 #0xFF, then a LOAD0 at 0xFF. The next instrAddress must be 0x00.
- Halt and mid-operation reset:
  - HALT12: halted=1 and instrRequest stays 0 for 20 cycles.
  - Separately, assert resetN=0 during EXECUTE of LOAD0 r0,#0xAA. register0Value must remain 0x00 and PC must return to 0.
